// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton debounce path.
// Contents:
//   key_state_e              - 2-bit debounce FSM state encoding
//   DEBOUNCE_10MS_50M        - 10 ms of stable input at 50 MHz
//   REPEAT_DELAY_500MS_50M   - 0.5 s hold before the first auto-repeat
//   REPEAT_PERIOD_100MS_50M  - 0.1 s between later auto-repeats
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEBOUNCE_10MS_50M       = 500000;
    localparam int REPEAT_DELAY_500MS_50M  = 25000000;
    localparam int REPEAT_PERIOD_100MS_50M = 5000000;

endpackage

// File: rtl/key_debounce_if.sv
// Signal bundle between a key source and its debouncer.
// Signals:
//   in_sync       - synchronized raw key level (source -> debouncer)
//   level         - debounced pressed level, 1 = pressed
//   press_pulse   - one-cycle strobe on an accepted press
//   release_pulse - one-cycle strobe on an accepted release
//   repeat_pulse  - one-cycle auto-repeat strobe while held
//   event_pulse   - press or repeat; the step command for control logic
// Modports:
//   master - the side that supplies in_sync and consumes the strobes
//   slave  - the debouncer itself
// The strobes carry a _pulse suffix because release, repeat and event
// are reserved words in SystemVerilog.
interface key_debounce_if;
    import key_pkg::*;

    logic in_sync;
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic event_pulse;

    modport master (
        output in_sync,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse,
        input  event_pulse
    );

    modport slave (
        input  in_sync,
        output level,
        output press_pulse,
        output release_pulse,
        output repeat_pulse,
        output event_pulse
    );

endinterface

// File: rtl/key_debounce.sv
// Debounces one synchronized pushbutton level and produces a clean
// pressed level plus press, release, auto-repeat and step-event strobes.
// A level change is accepted only after the new level has been seen on
// DEBOUNCE_CYCLES+1 consecutive edges; any bounce sends the FSM back to
// its origin state with no partial credit.
// Ports:
//   clk   - 50 MHz system clock
//   reset - asynchronous, active-high reset
//   key   - key_debounce_if.slave (in_sync in, level and strobes out)
// All outputs are registered. REPEAT_PERIOD is expected to be no larger
// than REPEAT_DELAY so that the repeat reload value stays non-negative.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS_50M,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS_50M,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    key_debounce_if.slave  key
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCNT_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE    = DCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_FIRE   = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);

    key_state_e        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;
    logic              event_q, event_d;
    logic              p;

    // Internal pressed level, independent of the board's key polarity.
    assign p = key.in_sync ^ ACTIVE_LOW;

    // Next-state and strobe logic. The repeat strobe fires on the edge
    // where rcnt would reach REPEAT_DELAY; the counter is reloaded so the
    // same compare value is hit again REPEAT_PERIOD edges later.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end
            HELD: begin
                if (!p) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == RCNT_FIRE) begin
                        repeat_d = 1'b1;
                        rcnt_d   = RCNT_RELOAD;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                // rcnt is left untouched so a release bounce does not
                // restart the repeat schedule.
                if (p) begin
                    state_d = HELD;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        event_d = press_d | repeat_d;
    end

    // State, counters and registered outputs; reset clears everything
    // immediately so an in-flight wait or repeat is dropped silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            event_q   <= event_d;
        end
    end

    assign key.level         = level_q;
    assign key.press_pulse   = press_q;
    assign key.release_pulse = release_q;
    assign key.repeat_pulse  = repeat_q;
    assign key.event_pulse   = event_q;

endmodule
